// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults, sync polarity constants and the
// decoded-raster bundle carried down the read-latency delay line.
package vga_timing_pkg;

    function automatic int axis_total(int active, int fp, int sync, int bp);
        return active + fp + sync + bp;
    endfunction

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int DEF_H_TOTAL =
        axis_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
    localparam int DEF_V_TOTAL =
        axis_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

    localparam bit POL_LOW  = 1'b0;
    localparam bit POL_HIGH = 1'b1;

    // Sync fields are logical (1 = asserted); polarity is applied at the pins.
    typedef struct packed {
        logic active;
        logic hs;
        logic vs;
        logic fs;
    } dec_t;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping counter plus active and sync range decode.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FP     = DEF_H_FP,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BP     = DEF_H_BP,
    parameter int CNT_W  = 11
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ce,
    input  logic             carry_in,
    output logic [CNT_W-1:0] count,
    output logic             wrap,
    output logic             active,
    output logic             sync
);

    localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);
    localparam logic [CNT_W-1:0] LAST     = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] ACT_END  = CNT_W'(ACTIVE);
    localparam logic [CNT_W-1:0] SYNC_BEG = CNT_W'(ACTIVE + FP);
    localparam logic [CNT_W-1:0] SYNC_END = CNT_W'(ACTIVE + FP + SYNC);

    assign wrap   = carry_in && (count == LAST);
    assign active = count < ACT_END;
    assign sync   = (count >= SYNC_BEG) && (count < SYNC_END);

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (ce && carry_in) begin
            count <= wrap ? '0 : count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// Parametrised VGA raster engine: linear framebuffer addressing and a
// read-latency-matched pipeline driving sync, blank and colour pins.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit HS_POL   = POL_LOW,
    parameter bit VS_POL   = POL_LOW,
    parameter int RGB_W    = 3,
    parameter int ADDR_W   = 19,
    parameter int CNT_W    = 11,
    parameter int RD_LAT   = 1
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              iPixEn,
    input  logic [RGB_W-1:0]  iColor,
    output logic [ADDR_W-1:0] oColorAddress,
    output logic              oHs,
    output logic              oVs,
    output logic              oActive,
    output logic [RGB_W-1:0]  oRGB,
    output logic              oFrameStart
);

    logic [CNT_W-1:0]  hcnt;
    logic [CNT_W-1:0]  vcnt;
    logic              h_wrap;
    logic              v_wrap;
    logic              h_act;
    logic              v_act;
    logic              h_sync;
    logic              v_sync;
    logic [ADDR_W-1:0] addr;
    dec_t              cur;
    dec_t              dl [RD_LAT];

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .CNT_W  (CNT_W)
    ) u_h (
        .clock    (Clock),
        .reset    (Reset),
        .ce       (iPixEn),
        .carry_in (1'b1),
        .count    (hcnt),
        .wrap     (h_wrap),
        .active   (h_act),
        .sync     (h_sync)
    );

    // v_wrap only fires with h_wrap, so it marks the last tick of a frame.
    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .CNT_W  (CNT_W)
    ) u_v (
        .clock    (Clock),
        .reset    (Reset),
        .ce       (iPixEn),
        .carry_in (h_wrap),
        .count    (vcnt),
        .wrap     (v_wrap),
        .active   (v_act),
        .sync     (v_sync)
    );

    always_comb begin
        cur        = '0;
        cur.active = h_act && v_act;
        cur.hs     = h_sync;
        cur.vs     = v_sync;
        cur.fs     = (hcnt == '0) && (vcnt == '0);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int i = 0; i < RD_LAT; i++) begin
                dl[i] <= '0;
            end
            addr        <= '0;
            oHs         <= ~HS_POL;
            oVs         <= ~VS_POL;
            oActive     <= 1'b0;
            oRGB        <= '0;
            oFrameStart <= 1'b0;
        end else if (iPixEn) begin
            dl[0] <= cur;
            for (int i = 1; i < RD_LAT; i++) begin
                dl[i] <= dl[i-1];
            end
            if (v_wrap) begin
                addr <= '0;
            end else if (cur.active) begin
                addr <= addr + ADDR_W'(1);
            end
            oHs         <= ~(dl[RD_LAT-1].hs ^ HS_POL);
            oVs         <= ~(dl[RD_LAT-1].vs ^ VS_POL);
            oActive     <= dl[RD_LAT-1].active;
            oRGB        <= dl[RD_LAT-1].active ? iColor : '0;
            oFrameStart <= dl[RD_LAT-1].fs;
        end
    end

    assign oColorAddress = addr;

endmodule
